// File: rtl/sobel_line_ctrl_if.sv
// Pixel-stream / sequencer-output bundle between the capture front end and
// the Sobel line controller.
interface sobel_line_ctrl_if #(
  parameter int COL_W = 13,
  parameter int ROW_W = 10
);
  logic             sof;
  logic             pix_valid;
  logic [COL_W-1:0] col;
  logic             buff_en;
  logic             shift_en;
  logic [ROW_W-1:0] row;
  logic             out_valid;
  logic             mask;
  logic             frame_done;
  logic             ovf;

  modport master (
    output sof, pix_valid,
    input  col, buff_en, shift_en, row, out_valid, mask, frame_done, ovf
  );

  modport slave (
    input  sof, pix_valid,
    output col, buff_en, shift_en, row, out_valid, mask, frame_done, ovf
  );
endinterface

// File: rtl/sobel_line_ctrl.sv
// Column/row sequencer for the 3-line Sobel window datapath.
// Optional SOBEL_BORDER_MASK_EN: flags border-column outputs in mask.
module sobel_line_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int COL_W    = 13,
  parameter int ROW_W    = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  sobel_line_ctrl_if.slave  bus
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_ACTIVE - 1);
  localparam logic [ROW_W-1:0] ROW_MAX  = ROW_W'(V_ACTIVE);

  typedef enum logic [1:0] {
    IDLE,
    LINE,
    SHIFT
  } state_e;

  state_e           state_q;
  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;
  logic [1:0]       fill_q;
  logic             shift_en_q;
  logic             frame_done_q;
  logic             ovf_q;

  logic             accept;
  logic             out_valid;
  logic [COL_W-1:0] col_cur;
  logic [ROW_W-1:0] row_base;
  logic [ROW_W-1:0] row_d;
  logic [1:0]       fill_base;
  logic [1:0]       fill_d;

  // sof restarts the frame in the same cycle, so the pixel it carries is
  // sequenced against cleared counters rather than the stale ones.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    accept    = bus.pix_valid & (bus.sof | (state_q == LINE));
    col_cur   = bus.sof ? '0 : col_q;
    row_base  = bus.sof ? '0 : row_q;
    fill_base = bus.sof ? '0 : fill_q;
    row_d     = (row_base == ROW_MAX) ? row_base : row_base + 1'b1;
    fill_d    = (fill_base == 2'd3) ? fill_base : fill_base + 2'd1;
    out_valid = accept & ~bus.sof & (fill_q == 2'd3);
  end

  // NOTE: sequential state uses non-blocking assignments only; a later
  // assignment in the same block overrides an earlier one for this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      fill_q       <= '0;
      shift_en_q   <= 1'b0;
      frame_done_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      shift_en_q   <= 1'b0;
      frame_done_q <= 1'b0;
      if (bus.sof || (state_q == LINE)) begin
        if (bus.sof) begin
          state_q <= LINE;
          col_q   <= '0;
          row_q   <= '0;
          fill_q  <= '0;
          ovf_q   <= 1'b0;
        end
        if (accept) begin
          if (col_cur == COL_LAST) begin
            // Row and fill advance on entry so the SHIFT cycle already
            // presents the new row alongside shift_en/frame_done.
            col_q        <= '0;
            state_q      <= SHIFT;
            shift_en_q   <= 1'b1;
            row_q        <= row_d;
            fill_q       <= fill_d;
            frame_done_q <= (row_d == ROW_MAX);
          end else begin
            col_q <= col_cur + 1'b1;
          end
        end
      end else if (state_q == SHIFT) begin
        if (bus.pix_valid) ovf_q <= 1'b1;
        state_q <= frame_done_q ? IDLE : LINE;
      end
    end
  end

  assign bus.col        = col_q;
  assign bus.buff_en    = accept;
  assign bus.shift_en   = shift_en_q;
  assign bus.row        = row_q;
  assign bus.out_valid  = out_valid;
  assign bus.frame_done = frame_done_q;
  assign bus.ovf        = ovf_q;

`ifdef SOBEL_BORDER_MASK_EN
  assign bus.mask = out_valid & ((col_q == '0) | (col_q == COL_LAST));
`else
  assign bus.mask = 1'b0;
`endif

endmodule

// File: tb/tb_sobel_line_ctrl.sv
// Directed bench for sobel_line_ctrl: idle, line sequencing, window fill,
// overflow, mid-line reset and a full (reduced-height) frame.
module tb_sobel_line_ctrl;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 32;  // reduced height keeps the full-frame run short
  localparam int COL_W    = 13;
  localparam int ROW_W    = 10;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   shift_cnt;
  int   mask_exp;

  sobel_line_ctrl_if #(.COL_W(COL_W), .ROW_W(ROW_W)) bus ();

  sobel_line_ctrl #(
    .H_ACTIVE(H_ACTIVE),
    .V_ACTIVE(V_ACTIVE),
    .COL_W   (COL_W),
    .ROW_W   (ROW_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive inputs just after a rising edge, then wait for the falling edge
  // where the caller samples outputs.
  task automatic cycle(input logic s, input logic v);
    @(posedge clk);
    #1;
    bus.sof       = s;
    bus.pix_valid = v;
    @(negedge clk);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    shift_cnt     = 0;
    rst_n         = 1'b0;
    bus.sof       = 1'b0;
    bus.pix_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values
    check("rst_col",        32'(bus.col),        0);
    check("rst_row",        32'(bus.row),        0);
    check("rst_buff_en",    32'(bus.buff_en),    0);
    check("rst_shift_en",   32'(bus.shift_en),   0);
    check("rst_out_valid",  32'(bus.out_valid),  0);
    check("rst_mask",       32'(bus.mask),       0);
    check("rst_frame_done", 32'(bus.frame_done), 0);
    check("rst_ovf",        32'(bus.ovf),        0);
    rst_n = 1'b1;

    // Pixels without sof are ignored
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1);
      check("idle_buff_en", 32'(bus.buff_en), 0);
      check("idle_col",     32'(bus.col),     0);
    end
    check("idle_ovf", 32'(bus.ovf), 0);

    // Lines 1..3: column sweep, one-cycle shift, window not yet full
    for (int l = 1; l <= 3; l++) begin
      for (int c = 0; c < H_ACTIVE; c++) begin
        cycle(l == 1 && c == 0, 1'b1);
        check("line_col",       32'(bus.col),       32'(c));
        check("line_buff_en",   32'(bus.buff_en),   1);
        check("line_out_valid", 32'(bus.out_valid), 0);
      end
      cycle(1'b0, 1'b0);
      check("blank_shift_en", 32'(bus.shift_en), 1);
      check("blank_col",      32'(bus.col),      0);
      check("blank_row",      32'(bus.row),      32'(l));
      check("blank_buff_en",  32'(bus.buff_en),  0);
      if (l == 1) begin
        cycle(1'b0, 1'b0);
        check("shift_one_cycle", 32'(bus.shift_en), 0);
      end
    end

    // Line 4: full window, border mask
    for (int c = 0; c < H_ACTIVE; c++) begin
      cycle(1'b0, 1'b1);
      check("l4_col",       32'(bus.col),       32'(c));
      check("l4_out_valid", 32'(bus.out_valid), 1);
`ifdef SOBEL_BORDER_MASK_EN
      mask_exp = (c == 0 || c == H_ACTIVE - 1) ? 1 : 0;
`else
      mask_exp = 0;
`endif
      check("l4_mask", 32'(bus.mask), 32'(mask_exp));
    end

    // pix_valid held across the line end: pixel dropped in SHIFT, ovf sticky
    cycle(1'b0, 1'b1);
    check("ovf_shift_en", 32'(bus.shift_en), 1);
    check("ovf_buff_en",  32'(bus.buff_en),  0);
    check("ovf_row",      32'(bus.row),      4);
    cycle(1'b0, 1'b1);
    check("ovf_set",       32'(bus.ovf),     1);
    check("ovf_next_col",  32'(bus.col),     0);
    check("ovf_next_buff", 32'(bus.buff_en), 1);

    // Line 5 up to col 300, then asynchronous reset mid-line
    for (int c = 1; c < 300; c++) cycle(1'b0, 1'b1);
    @(posedge clk);
    #1;
    check("pre_rst_col", 32'(bus.col), 300);
    rst_n = 1'b0;
    #1;
    check("mid_rst_col",       32'(bus.col),       0);
    check("mid_rst_row",       32'(bus.row),       0);
    check("mid_rst_buff_en",   32'(bus.buff_en),   0);
    check("mid_rst_out_valid", 32'(bus.out_valid), 0);
    check("mid_rst_ovf",       32'(bus.ovf),       0);
    check("mid_rst_shift_en",  32'(bus.shift_en),  0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1);
      check("post_rst_buff_en", 32'(bus.buff_en), 0);
      check("post_rst_col",     32'(bus.col),     0);
    end

    // Full frame from sof
    for (int r = 0; r < V_ACTIVE; r++) begin
      for (int c = 0; c < H_ACTIVE; c++) begin
        cycle(r == 0 && c == 0, 1'b1);
        check("frm_col",       32'(bus.col),       32'(c));
        check("frm_buff_en",   32'(bus.buff_en),   1);
        check("frm_out_valid", 32'(bus.out_valid), (r >= 3) ? 1 : 0);
        if (r == 0 && c == 0) begin
          check("frm_start_row", 32'(bus.row), 0);
          check("frm_start_ovf", 32'(bus.ovf), 0);
        end
      end
      cycle(1'b0, 1'b0);
      if (bus.shift_en) shift_cnt++;
      check("frm_row",        32'(bus.row),        32'(r + 1));
      check("frm_frame_done", 32'(bus.frame_done), (r == V_ACTIVE - 1) ? 1 : 0);
    end
    check("frm_shift_count", 32'(shift_cnt), 32'(V_ACTIVE));

    cycle(1'b0, 1'b1);
    check("done_pulse_end", 32'(bus.frame_done), 0);
    check("done_shift_end", 32'(bus.shift_en),   0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1);
      check("after_frame_buff_en", 32'(bus.buff_en), 0);
      check("after_frame_col",     32'(bus.col),     0);
      check("after_frame_row",     32'(bus.row),     32'(V_ACTIVE));
    end
    check("after_frame_ovf", 32'(bus.ovf), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
